// File: rtl/mag_pow_pkg.sv
// Shared constants and helpers for the magnitude-power basis generator.
// Latency: n/a (package). Backpressure: n/a.
// Provides the alpha-max-beta-min shift amounts, tree-depth helpers and the
// round-half-up/saturate step applied after every power-tree multiply.
package mag_pow_pkg;

    // Widest DW the rounding helper supports (products carried in 2*MAX_DW bits).
    localparam int MAX_DW   = 32;

    // beta*min is approximated as (min>>2) + (min>>3) = 0.375*min.
    localparam int BETA_SH0 = 2;
    localparam int BETA_SH1 = 3;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Tree level at which |x|^k is produced: m_k = m_ceil(k/2) * m_floor(k/2).
    function automatic int tree_depth(input int k);
        return clog2(k);
    endfunction

    // Rescale a Q2.(2dw-2) product back to Q1.(dw-1) with round-half-up.
    // Returns {sat, value}; value bits above dw are always zero.
    // An overflowing product (top bit set, or rounding carries out) clamps to
    // all-ones in dw bits and raises sat.
    function automatic logic [MAX_DW:0] round_sat(input logic [2*MAX_DW-1:0] p,
                                                  input int dw);
        logic [2*MAX_DW-1:0] mask;
        logic [2*MAX_DW-1:0] sum;
        logic                sat;
        mask = ((2*MAX_DW)'(1) << dw) - (2*MAX_DW)'(1);
        sum  = ((p >> (dw - 1)) & mask) + (2*MAX_DW)'(p[dw-2]);
        sat  = p[2*dw-1] | sum[dw];
        return {sat, sat ? mask[MAX_DW-1:0] : sum[MAX_DW-1:0]};
    endfunction

endpackage

// File: rtl/mag_pow_gen_mag_ab_approx.sv
// Two-stage alpha-max-beta-min magnitude: |I|,|Q| register then m1 register.
// Latency: 2 cycles from sample to m1. Backpressure: none, one sample per clock.
// Ports: clk, reset_b (async, active-low); in_valid gates the sample (invalid
// cycles inject zeros); sig_i/sig_q signed DW-bit I/Q; m1 unsigned Q1.(DW-1).
module mag_ab_approx
    import mag_pow_pkg::*;
#(
    parameter int DW = 20
)
(
    input  logic          clk,
    input  logic          reset_b,
    input  logic          in_valid,
    input  logic [DW-1:0] sig_i,
    input  logic [DW-1:0] sig_q,
    output logic [DW-1:0] m1
);

    localparam logic [DW-1:0] NEG_FULL = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] POS_FULL = {1'b0, {(DW-1){1'b1}}};

    // |x| with the one unrepresentable case (-2^(DW-1)) clamped to full scale.
    function automatic logic [DW-1:0] sat_abs(input logic [DW-1:0] x);
        if (!x[DW-1]) begin
            return x;
        end
        if (x == NEG_FULL) begin
            return POS_FULL;
        end
        return -x;
    endfunction

    logic [DW-1:0] a_r;
    logic [DW-1:0] b_r;
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;
    logic [DW-1:0] m1_next;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            a_r <= '0;
            b_r <= '0;
        end else begin
            a_r <= in_valid ? sat_abs(sig_i) : '0;
            b_r <= in_valid ? sat_abs(sig_q) : '0;
        end
    end

    // Both inputs are at most 2^(DW-1)-1, so max + 0.375*min stays below 2^DW.
    always_comb begin
        mx      = (a_r >= b_r) ? a_r : b_r;
        mn      = (a_r >= b_r) ? b_r : a_r;
        m1_next = mx + (mn >> BETA_SH0) + (mn >> BETA_SH1);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            m1 <= '0;
        end else begin
            m1 <= m1_next;
        end
    end

endmodule

// File: rtl/mag_pow_gen.sv
// Streaming |x|^0..|x|^(ORDER-1) basis generator for the DPD memory polynomial.
// Latency: 3 + ceil(log2(ORDER-1)) cycles. Backpressure: none, 1 sample/clock.
// Ports: clk, reset_b (async, active-low); in_valid, sig_in_i, sig_in_q sample
// in; sat_clr clears sat_flag; out_valid, mag_out (slice k = |x|^k), sat_flag
// (sticky: some power term saturated on a valid output since the last clear).
module mag_pow_gen
    import mag_pow_pkg::*;
#(
    parameter int DW    = 20,
    parameter int ORDER = 5
)
(
    input  logic                clk,
    input  logic                reset_b,
    input  logic                in_valid,
    input  logic [DW-1:0]       sig_in_i,
    input  logic [DW-1:0]       sig_in_q,
    input  logic                sat_clr,
    output logic                out_valid,
    output logic [ORDER*DW-1:0] mag_out,
    output logic                sat_flag
);

    // Number of multiplier levels; the deepest term is |x|^(ORDER-1).
    localparam int D = tree_depth(ORDER - 1);
    localparam logic [DW-1:0] UNITY = {1'b0, {(DW-1){1'b1}}};

    // Bit 0: abs stage, bit 1: m1 stage, bit 1+l: tree level l.
    logic [D+1:0]  vld_pipe;
    logic [DW-1:0] m1;
    logic [DW-1:0] fin [1:ORDER-1];
    logic          fin_sat;

    mag_ab_approx #(.DW(DW)) u_mag (
        .clk      (clk),
        .reset_b  (reset_b),
        .in_valid (in_valid),
        .sig_i    (sig_in_i),
        .sig_q    (sig_in_q),
        .m1       (m1)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[D:0], in_valid};
        end
    end

    if (D == 0) begin : g_no_tree
        assign fin[1]  = m1;
        assign fin_sat = 1'b0;
    end else begin : g_tree
        // lvl[l][k] holds |x|^k at level l; only terms with depth <= l exist.
        logic [DW-1:0]          lvl [1:D][1:ORDER-1];
        logic [D:1][ORDER-1:1]  term_sat;
        logic [D:1]             sat_pipe;

        for (genvar l = 1; l <= D; l++) begin : g_lvl
            for (genvar k = 1; k < ORDER; k++) begin : g_term
                if (tree_depth(k) == l) begin : g_mul
                    logic [DW-1:0]   op_a;
                    logic [DW-1:0]   op_b;
                    logic [2*DW-1:0] prod;
                    logic [MAX_DW:0] rs_full;
                    logic            rs_unused;

                    if (l == 1) begin : g_src_m1
                        assign op_a = m1;
                        assign op_b = m1;
                    end else begin : g_src_lvl
                        assign op_a = lvl[l-1][(k+1)/2];
                        assign op_b = lvl[l-1][k/2];
                    end

                    assign prod           = {{DW{1'b0}}, op_a} * {{DW{1'b0}}, op_b};
                    assign rs_full        = round_sat((2*MAX_DW)'(prod), DW);
                    assign rs_unused      = ^rs_full;
                    assign term_sat[l][k] = rs_full[MAX_DW];

                    always_ff @(posedge clk or negedge reset_b) begin
                        if (!reset_b) begin
                            lvl[l][k] <= '0;
                        end else begin
                            lvl[l][k] <= rs_full[DW-1:0];
                        end
                    end
                end else if (tree_depth(k) < l) begin : g_dly
                    // Term already computed: carry it down so all terms align.
                    assign term_sat[l][k] = 1'b0;
                    if (l == 1) begin : g_dly_m1
                        always_ff @(posedge clk or negedge reset_b) begin
                            if (!reset_b) begin
                                lvl[l][k] <= '0;
                            end else begin
                                lvl[l][k] <= m1;
                            end
                        end
                    end else begin : g_dly_lvl
                        always_ff @(posedge clk or negedge reset_b) begin
                            if (!reset_b) begin
                                lvl[l][k] <= '0;
                            end else begin
                                lvl[l][k] <= lvl[l-1][k];
                            end
                        end
                    end
                end else begin : g_none
                    assign term_sat[l][k] = 1'b0;
                end
            end
        end

        // Saturation events ride alongside the data they belong to.
        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                sat_pipe <= '0;
            end else begin
                sat_pipe[1] <= |term_sat[1];
                for (int l = 2; l <= D; l++) begin
                    sat_pipe[l] <= sat_pipe[l-1] | (|term_sat[l]);
                end
            end
        end

        for (genvar k = 1; k < ORDER; k++) begin : g_fin
            assign fin[k] = lvl[D][k];
        end
        assign fin_sat = sat_pipe[D];
    end

    // Output stage. Invalid samples were zeroed at the input, so only slice 0
    // (the constant |x|^0) needs explicit gating.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            out_valid <= 1'b0;
            mag_out   <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid       <= vld_pipe[D+1];
            mag_out[DW-1:0] <= vld_pipe[D+1] ? UNITY : '0;
            for (int k = 1; k < ORDER; k++) begin
                mag_out[k*DW +: DW] <= fin[k];
            end
            // A new saturation event beats a simultaneous clear.
            if (vld_pipe[D+1] && fin_sat) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mag_pow_gen.sv
// Self-checking bench for mag_pow_gen: ORDER=5, 2 and 9 instances share stimulus.
// Latency: n/a. Backpressure: n/a.
// Reference model computes each basis term directly from the arithmetic rules.
module tb_mag_pow_gen;

    localparam int DW = 20;

    logic              clk;
    logic              reset_b;
    logic              in_valid;
    logic [DW-1:0]     sig_in_i;
    logic [DW-1:0]     sig_in_q;
    logic              sat_clr;

    logic              ov5, ov2, ov9;
    logic [5*DW-1:0]   mag5;
    logic [2*DW-1:0]   mag2;
    logic [9*DW-1:0]   mag9;
    logic              sf5, sf2, sf9;

    mag_pow_gen #(.DW(DW), .ORDER(5)) u_dut5 (
        .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .sig_in_i(sig_in_i),
        .sig_in_q(sig_in_q), .sat_clr(sat_clr), .out_valid(ov5), .mag_out(mag5),
        .sat_flag(sf5));

    mag_pow_gen #(.DW(DW), .ORDER(2)) u_dut2 (
        .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .sig_in_i(sig_in_i),
        .sig_in_q(sig_in_q), .sat_clr(sat_clr), .out_valid(ov2), .mag_out(mag2),
        .sat_flag(sf2));

    mag_pow_gen #(.DW(DW), .ORDER(9)) u_dut9 (
        .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .sig_in_i(sig_in_i),
        .sig_in_q(sig_in_q), .sat_clr(sat_clr), .out_valid(ov9), .mag_out(mag9),
        .sat_flag(sf9));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Stimulus history, one entry per clock step; entries below first_ok
    // predate the last reset and never reach an output.
    int n        = 0;
    int first_ok = 0;
    bit h_v [0:4095];
    int h_i [0:4095];
    int h_q [0:4095];
    bit sat_m [0:2];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {any_sat, basis vector} for one sample.
    function automatic logic [256:0] model_vec(input bit v, input int i, input int q,
                                               input int order);
        longint m [0:8];
        longint a, b, mx, mn, p, r;
        bit sat;
        logic [255:0] vec;
        if (!v) return '0;
        a = (i < 0) ? -longint'(i) : longint'(i);
        b = (q < 0) ? -longint'(q) : longint'(q);
        if (a > 524287) a = 524287;
        if (b > 524287) b = 524287;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        m[0] = 524287;
        m[1] = mx + mn / 4 + mn / 8;
        sat = 1'b0;
        for (int k = 2; k < order; k++) begin
            p = m[(k+1)/2] * m[k/2];
            r = (p + 262144) / 524288;
            if (r > 1048575) begin
                r = 1048575;
                sat = 1'b1;
            end
            m[k] = r;
        end
        vec = '0;
        for (int k = 0; k < order; k++) vec[k*20 +: 20] = 20'(m[k]);
        return {sat, vec};
    endfunction

    task automatic check_one(input int idx, input string nm, input int lat, input int order,
                             input logic ov, input logic [255:0] mo, input logic sf,
                             input bit clr);
        int src;
        bit ev;
        logic [256:0] e;
        src = n - (lat - 1);
        ev = 1'b0;
        e = '0;
        if (src >= first_ok) begin
            ev = h_v[src];
            e = model_vec(h_v[src], h_i[src], h_q[src], order);
        end
        if (ev && e[256]) sat_m[idx] = 1'b1;
        else if (clr) sat_m[idx] = 1'b0;
        chk({nm, "_vld"}, 256'(ov), 256'(ev));
        chk({nm, "_mag"}, mo, e[255:0]);
        chk({nm, "_sat"}, 256'(sf), 256'(sat_m[idx]));
    endtask

    // Drive one sample for one clock, then check all three instances.
    task automatic step(input bit v, input int i, input int q, input bit clr);
        in_valid = v;
        sig_in_i = i[DW-1:0];
        sig_in_q = q[DW-1:0];
        sat_clr  = clr;
        h_v[n] = v;
        h_i[n] = i;
        h_q[n] = q;
        @(posedge clk);
        #1;
        check_one(0, "o5", 5, 5, ov5, 256'(mag5), sf5, clr);
        check_one(1, "o2", 3, 2, ov2, 256'(mag2), sf2, clr);
        check_one(2, "o9", 6, 9, ov9, 256'(mag9), sf9, clr);
        n++;
    endtask

    task automatic idle(input int cnt);
        for (int c = 0; c < cnt; c++) step(1'b0, int'($urandom_range(0, 1048575)) - 524288, 0, 1'b0);
    endtask

    task automatic chk_zero_all(input string tag);
        chk({tag, "_v5"}, 256'(ov5), '0);
        chk({tag, "_m5"}, 256'(mag5), '0);
        chk({tag, "_s5"}, 256'(sf5), '0);
        chk({tag, "_v2"}, 256'(ov2), '0);
        chk({tag, "_m2"}, 256'(mag2), '0);
        chk({tag, "_s2"}, 256'(sf2), '0);
        chk({tag, "_v9"}, 256'(ov9), '0);
        chk({tag, "_m9"}, 256'(mag9), '0);
        chk({tag, "_s9"}, 256'(sf9), '0);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        sat_clr  = 1'b0;
        sig_in_i = '0;
        sig_in_q = '0;
        reset_b  = 1'b0;
        #2;
        chk_zero_all("rst_async");
        @(posedge clk);
        #1;
        chk_zero_all("rst_hold");
        reset_b  = 1'b1;
        first_ok = n;
        for (int d = 0; d < 3; d++) sat_m[d] = 1'b0;
    endtask

    function automatic int rnd_s20();
        logic [19:0] r;
        r = 20'($urandom);
        case ($urandom_range(0, 7))
            0: return -524288;
            1: return 524287;
            default: return int'($signed(r));
        endcase
    endfunction

    initial begin
        reset_b  = 1'b0;
        in_valid = 1'b0;
        sig_in_i = '0;
        sig_in_q = '0;
        sat_clr  = 1'b0;
        for (int d = 0; d < 3; d++) sat_m[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_all("reset");
        reset_b = 1'b1;
        idle(2);

        // Half-scale real sample: exact powers of 0.5.
        step(1'b1, 262144, 0, 1'b0);
        idle(2);
        chk("o2_lat3_vld", 256'(ov2), 256'(1));
        chk("o2_lat3_s1", 256'(mag2[DW +: DW]), 256'(262144));
        idle(1);
        chk("o5_early_vld", 256'(ov5), 256'(0));
        idle(1);
        chk("o5_lat5_vld", 256'(ov5), 256'(1));
        chk("o5_s0", 256'(mag5[0 +: DW]), 256'(524287));
        chk("o5_s1", 256'(mag5[DW +: DW]), 256'(262144));
        chk("o5_s2", 256'(mag5[2*DW +: DW]), 256'(131072));
        chk("o5_s3", 256'(mag5[3*DW +: DW]), 256'(65536));
        chk("o5_s4", 256'(mag5[4*DW +: DW]), 256'(32768));
        chk("o5_nosat", 256'(sf5), 256'(0));
        idle(1);
        chk("o9_lat6_vld", 256'(ov9), 256'(1));
        chk("o9_s8", 256'(mag9[8*DW +: DW]), 256'(2048));

        // Full-scale negative I and Q: saturating higher powers.
        step(1'b1, -524288, -524288, 1'b0);
        idle(3);
        chk("sat_before", 256'(sf5), 256'(0));
        idle(1);
        chk("sat_vld", 256'(ov5), 256'(1));
        chk("sat_s0", 256'(mag5[0 +: DW]), 256'(524287));
        chk("sat_s1", 256'(mag5[DW +: DW]), 256'(720893));
        chk("sat_s2", 256'(mag5[2*DW +: DW]), 256'(991224));
        chk("sat_s3", 256'(mag5[3*DW +: DW]), 256'(1048575));
        chk("sat_s4", 256'(mag5[4*DW +: DW]), 256'(1048575));
        chk("sat_rise", 256'(sf5), 256'(1));
        idle(4);
        chk("sat_hold", 256'(sf5), 256'(1));
        step(1'b0, 0, 0, 1'b1);
        chk("sat_clr", 256'(sf5), 256'(0));

        // Clear coinciding with a saturating output: the set wins.
        step(1'b1, -524288, 524287, 1'b0);
        idle(3);
        step(1'b0, 0, 0, 1'b1);
        chk("set_wins", 256'(sf5), 256'(1));
        step(1'b0, 0, 0, 1'b1);
        chk("clr_alone", 256'(sf5), 256'(0));
        step(1'b0, 0, 0, 1'b1);

        // Ramp with random gaps; gap cycles carry junk data that must not leak.
        for (int r = 0; r < 256; r++) begin
            while ($urandom_range(0, 4) == 0) idle(1);
            step(1'b1, r * 1024, 0, 1'b0);
        end
        idle(7);

        // Mid-stream reset with samples in flight.
        step(1'b1, -524288, -524288, 1'b0);
        idle(6);
        for (int s = 0; s < 3; s++) step(1'b1, rnd_s20(), rnd_s20(), 1'b0);
        pulse_reset();
        step(1'b1, 262144, 131072, 1'b0);
        idle(3);
        chk("post_rst_early", 256'(ov5), 256'(0));
        idle(1);
        chk("post_rst_lat", 256'(ov5), 256'(1));
        idle(3);

        // Random traffic with occasional clears.
        for (int s = 0; s < 300; s++) begin
            step(bit'($urandom_range(0, 3) != 0), rnd_s20(), rnd_s20(),
                 bit'($urandom_range(0, 9) == 0));
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
